// File: rtl/spi_sfr_pkg.sv
// Shared SFR address map, status-bit positions and sequencer state encoding
// for the SPI SFR driver.
package spi_sfr_pkg;

    localparam logic [1:0] ADDR_CR1 = 2'b00;
    localparam logic [1:0] ADDR_CR2 = 2'b01;
    localparam logic [1:0] ADDR_BR  = 2'b10;
    localparam logic [1:0] ADDR_DR1 = 2'b11;

    localparam logic [2:0] RADDR_SR  = 3'b011;
    localparam logic [2:0] RADDR_DR2 = 3'b101;

    localparam int SR_DONE_BIT = 0;

    typedef enum logic [3:0] {
        ST_CFG_CR1,
        ST_CFG_CR2,
        ST_CFG_BR,
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/spi_sfr_driver.sv
// Sequencer: programs the SPI controller once after reset, then turns byte requests into
// DR1 write / SR poll / DR2 read SFR transactions. All outputs registered; no rsp backpressure.
module spi_sfr_driver
    import spi_sfr_pkg::*;
#(
    parameter logic [7:0] CR1_CFG = 8'h10,
    parameter logic [7:0] CR2_CFG = 8'h00,
    parameter logic [7:0] BR_CFG  = 8'h03,
    parameter int         TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_data,
    input  logic [7:0] req_ssn,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic [1:0] sfraddr_w,
    output logic       sfrwe,
    output logic [7:0] spidata_o,
    output logic [2:0] sfraddr_r,
    input  logic [7:0] sfr_data_i,
    output logic [7:0] spssn_o
);

    localparam int              CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_done_q, prev_done_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          busy_q, busy_d;
    logic [1:0]    sfraddr_w_q, sfraddr_w_d;
    logic          sfrwe_q, sfrwe_d;
    logic [7:0]    spidata_q, spidata_d;
    logic [2:0]    sfraddr_r_q, sfraddr_r_d;
    logic [7:0]    spssn_q, spssn_d;
    logic          cur_done;
    logic          tmo_hit;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prev_done_d = prev_done_q;
        rsp_data_d  = rsp_data_q;
        spssn_d     = spssn_q;
        cur_done    = sfr_data_i[SR_DONE_BIT];
        tmo_hit     = 1'b0;

        case (state_q)
            // Reset parks here with outputs idle; stay one cycle so the CR1 write is actually driven.
            ST_CFG_CR1: state_d = sfrwe_q ? ST_CFG_CR2 : ST_CFG_CR1;
            ST_CFG_CR2: state_d = ST_CFG_BR;
            ST_CFG_BR:  state_d = ST_IDLE;
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = ST_LOAD;
                    spssn_d = req_ssn;
                end
            end
            ST_LOAD: begin
                state_d     = ST_WAIT;
                cnt_d       = '0;
                prev_done_d = 1'b1;
            end
            ST_WAIT: begin
                prev_done_d = cur_done;
                cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                // Only a fresh 0->1 edge counts; a done bit left over from the last transfer is ignored.
                if (!prev_done_q && cur_done) begin
                    state_d = ST_RD_REQ;
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = ST_RESP;
                    tmo_hit    = 1'b1;
                    rsp_data_d = 8'h00;
                end
            end
            ST_RD_REQ: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                state_d    = ST_RESP;
                rsp_data_d = sfr_data_i;
            end
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_CFG_CR1;
        endcase

        // Outputs are decoded from the next state so they line up with the state they belong to.
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        busy_d        = 1'b1;
        sfrwe_d       = 1'b0;
        sfraddr_w_d   = 2'b00;
        spidata_d     = 8'h00;
        sfraddr_r_d   = 3'b000;

        case (state_d)
            ST_CFG_CR1: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = ADDR_CR1;
                spidata_d   = CR1_CFG;
            end
            ST_CFG_CR2: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = ADDR_CR2;
                spidata_d   = CR2_CFG;
            end
            ST_CFG_BR: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = ADDR_BR;
                spidata_d   = BR_CFG;
            end
            ST_IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            ST_LOAD: begin
                sfrwe_d     = 1'b1;
                sfraddr_w_d = ADDR_DR1;
                spidata_d   = req_data;
                // SR read is issued here so the first WAIT cycle already sees real status.
                sfraddr_r_d = RADDR_SR;
            end
            ST_WAIT:   sfraddr_r_d = RADDR_SR;
            ST_RD_REQ: sfraddr_r_d = RADDR_DR2;
            ST_RESP: begin
                rsp_valid_d   = 1'b1;
                rsp_timeout_d = tmo_hit;
                spssn_d       = 8'hFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_CFG_CR1;
            cnt_q         <= '0;
            prev_done_q   <= 1'b1;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b1;
            sfraddr_w_q   <= 2'b00;
            sfrwe_q       <= 1'b0;
            spidata_q     <= 8'h00;
            sfraddr_r_q   <= 3'b000;
            spssn_q       <= 8'hFF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_done_q   <= prev_done_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            sfraddr_w_q   <= sfraddr_w_d;
            sfrwe_q       <= sfrwe_d;
            spidata_q     <= spidata_d;
            sfraddr_r_q   <= sfraddr_r_d;
            spssn_q       <= spssn_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign sfraddr_w   = sfraddr_w_q;
    assign sfrwe       = sfrwe_q;
    assign spidata_o   = spidata_q;
    assign sfraddr_r   = sfraddr_r_q;
    assign spssn_o     = spssn_q;

endmodule

// File: tb/tb_spi_sfr_driver.sv
// Bench for spi_sfr_driver: behavioural SPI-controller SFR model plus a response scoreboard.
module tb_spi_sfr_driver;

    localparam int TB_TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_data = 8'h00;
    logic [7:0] req_ssn = 8'hFF;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic [1:0] sfraddr_w;
    logic       sfrwe;
    logic [7:0] spidata_o;
    logic [2:0] sfraddr_r;
    logic [7:0] sfr_data_i = 8'h00;
    logic [7:0] spssn_o;

    spi_sfr_driver #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_ssn(req_ssn),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy),
        .sfraddr_w(sfraddr_w), .sfrwe(sfrwe), .spidata_o(spidata_o),
        .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i), .spssn_o(spssn_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] data;
        logic       to;
        int         lat;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [33:0] RST_VEC = {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 3'b000, 8'hFF};
    logic [33:0] outs_vec;
    assign outs_vec = {req_ready, rsp_valid, rsp_data, rsp_timeout, busy, sfrwe,
                       sfraddr_w, spidata_o, sfraddr_r, spssn_o};

    // Controller model: registered SFR read; done bit shaped per transfer relative to the DR1 write.
    int         next_rise = -1, next_fall = 0;
    int         cur_rise = -1, cur_fall = 0;
    int         launch_cnt = 0;
    logic       sr_done = 1'b0;
    logic [7:0] dr2 = 8'h00;
    int         rsp_cnt = 0;

    always @(posedge clk) begin
        sfr_data_i <= (sfraddr_r == 3'b011) ? {7'b0, sr_done} :
                      (sfraddr_r == 3'b101) ? dr2 : 8'h00;
        if (sfrwe && sfraddr_w == 2'b11) begin
            launch_cnt <= 1;
            cur_rise   <= next_rise;
            cur_fall   <= next_fall;
            if (next_fall == 0) sr_done <= 1'b0;
        end else begin
            launch_cnt <= launch_cnt + 1;
            if (launch_cnt == cur_fall) sr_done <= 1'b0;
            if (launch_cnt == cur_rise) sr_done <= 1'b1;
        end
    end

    always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

    task automatic wait_ready(input string name);
        int w = 0;
        while (!req_ready && w < 200) begin @(negedge clk); w++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL %s_ready_wait: req_ready got 0 want 1 within 200 cycles", name);
        end
    endtask

    task automatic test_config_seq(input string name);
        logic [1:0] ea[3] = '{2'b00, 2'b01, 2'b10};
        logic [7:0] ed[3] = '{8'h10, 8'h00, 8'h03};
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({sfrwe, sfraddr_w, spidata_o, req_ready, busy} !== {1'b1, ea[i], ed[i], 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL %s_cfg%0d: we/addr/data/rdy/busy got %b/%b/%h/%b/%b want 1/%b/%h/0/1",
                         name, i, sfrwe, sfraddr_w, spidata_o, req_ready, busy, ea[i], ed[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({req_ready, busy, sfrwe} !== 3'b100) begin
            failures++;
            $display("FAIL %s_ready_c4: rdy/busy/we got %b%b%b want 100", name, req_ready, busy, sfrwe);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_vec !== RST_VEC) begin
            failures++;
            $display("FAIL reset_vals: got %h want %h", outs_vec, RST_VEC);
        end
        test_config_seq("reset");
    endtask

    // Runs one request through; latency counted from the accept cycle to rsp_valid.
    task automatic run_xfer(input string name, input logic [7:0] d, input logic [7:0] ssn,
                            input int rise, input int fall, input logic [7:0] rx, input logic to);
        exp_t e;
        int   n;
        wait_ready(name);
        next_rise = rise; next_fall = fall; dr2 = rx;
        req_valid = 1'b1; req_data = d; req_ssn = ssn;
        exp_q.push_back('{data: to ? 8'h00 : rx, to: to, lat: to ? TB_TIMEOUT + 3 : rise + 6});
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({sfrwe, sfraddr_w, spidata_o, spssn_o, req_ready} !== {1'b1, 2'b11, d, ssn, 1'b0}) begin
            failures++;
            $display("FAIL %s_load: we/addr/data/ssn/rdy got %b/%b/%h/%h/%b want 1/11/%h/%h/0",
                     name, sfrwe, sfraddr_w, spidata_o, spssn_o, req_ready, d, ssn);
        end
        n = 1;
        while (!rsp_valid && n < 200) begin
            @(negedge clk); n++;
            if (n == 5) begin
                checks++;
                if ({spssn_o, busy, sfraddr_r} !== {ssn, 1'b1, 3'b011}) begin
                    failures++;
                    $display("FAIL %s_wait: ssn/busy/raddr got %h/%b/%b want %h/1/011",
                             name, spssn_o, busy, sfraddr_r, ssn);
                end
            end
        end
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout} !== {1'b1, e.data, e.to} || n != e.lat) begin
            failures++;
            $display("FAIL %s_rsp: vld/data/to/lat got %b/%h/%b/%0d want 1/%h/%b/%0d",
                     name, rsp_valid, rsp_data, rsp_timeout, n, e.data, e.to, e.lat);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, spssn_o, req_ready, busy} !== {1'b0, 8'hFF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL %s_after: vld/ssn/rdy/busy got %b/%h/%b/%b want 0/ff/1/0",
                     name, rsp_valid, spssn_o, req_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_xfer("basic", 8'hA5, 8'hFE, 20, 0, 8'h3C, 1'b0);
    endtask

    task automatic test_stale_done();
        // Done bit still high from the previous transfer: falls after 5, rises after 12.
        run_xfer("stale", 8'h96, 8'hFD, 12, 5, 8'hE1, 1'b0);
    endtask

    task automatic test_timeout();
        run_xfer("timeout", 8'h42, 8'hFB, -1, 0, 8'h99, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   n;
        wait_ready("b2b");
        next_rise = 4; next_fall = 0; dr2 = 8'h5A;
        req_valid = 1'b1; req_data = 8'h11; req_ssn = 8'hF0;
        exp_q.push_back('{data: 8'h5A, to: 1'b0, lat: 10});
        @(negedge clk);
        checks++;
        if ({sfrwe, sfraddr_w, spidata_o} !== {1'b1, 2'b11, 8'h11}) begin
            failures++;
            $display("FAIL b2b_load1: we/addr/data got %b/%b/%h want 1/11/11", sfrwe, sfraddr_w, spidata_o);
        end
        req_data = 8'h22; req_ssn = 8'h0F;
        exp_q.push_back('{data: 8'hC3, to: 1'b0, lat: 10});
        n = 1;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout} !== {1'b1, e.data, e.to} || n != e.lat) begin
            failures++;
            $display("FAIL b2b_rsp1: vld/data/to/lat got %b/%h/%b/%0d want 1/%h/%b/%0d",
                     rsp_valid, rsp_data, rsp_timeout, n, e.data, e.to, e.lat);
        end
        dr2 = 8'hC3;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: req_ready got %b want 1 right after RESP", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({sfrwe, sfraddr_w, spidata_o, spssn_o} !== {1'b1, 2'b11, 8'h22, 8'h0F}) begin
            failures++;
            $display("FAIL b2b_load2: we/addr/data/ssn got %b/%b/%h/%h want 1/11/22/0f",
                     sfrwe, sfraddr_w, spidata_o, spssn_o);
        end
        n = 1;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_data, rsp_timeout} !== {1'b1, e.data, e.to} || n != e.lat) begin
            failures++;
            $display("FAIL b2b_rsp2: vld/data/to/lat got %b/%h/%b/%0d want 1/%h/%b/%0d",
                     rsp_valid, rsp_data, rsp_timeout, n, e.data, e.to, e.lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        wait_ready("midrst");
        next_rise = -1; next_fall = 0;
        req_valid = 1'b1; req_data = 8'h77; req_ssn = 8'h7F;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        base = rsp_cnt;
        checks++;
        if ({busy, spssn_o, sfraddr_r} !== {1'b1, 8'h7F, 3'b011}) begin
            failures++;
            $display("FAIL midrst_wait: busy/ssn/raddr got %b/%h/%b want 1/7f/011", busy, spssn_o, sfraddr_r);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_vec !== RST_VEC) begin
            failures++;
            $display("FAIL midrst_vals: got %h want %h", outs_vec, RST_VEC);
        end
        repeat (3) @(negedge clk);
        test_config_seq("midrst");
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp_cnt != base) begin
            failures++;
            $display("FAIL midrst_norsp: rsp pulses got %0d want %0d", rsp_cnt - base, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stale_done();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
